// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared constants for the shift unit
package shift_pkg;

   localparam int SH_WIDTH = 32;
   localparam int SH_SHW   = 5;

   localparam logic [1:0] SH_SLL  = 2'b00;
   localparam logic [1:0] SH_SRL  = 2'b01;
   localparam logic [1:0] SH_SRA  = 2'b10;
   localparam logic [1:0] SH_ROTR = 2'b11;

endpackage

// File: rtl/shift_core.sv
// rtl/shift_core.sv - combinational log-stage barrel shifter
// Left shifts reuse the right-shift stages by bit-reversing the operand and the result.
module shift_core
   import shift_pkg::*;
#(
   parameter int WIDTH = SH_WIDTH,
   parameter int SHW   = SH_SHW
) (
   input  logic [1:0]       op,
   input  logic [SHW-1:0]   shamt,
   input  logic [WIDTH-1:0] Data,
   output logic [WIDTH-1:0] shifted
);

   logic             is_sll;
   logic             is_rot;
   logic             fill;
   logic [WIDTH-1:0] data_rev;
   logic [WIDTH-1:0] stage_out_rev;
   logic [WIDTH-1:0] stage [0:SHW];

   assign is_sll = (op == SH_SLL);
   assign is_rot = (op == SH_ROTR);
   assign fill   = (op == SH_SRA) & Data[WIDTH-1];

   for (genvar b = 0; b < WIDTH; b++) begin : g_rev
      assign data_rev[b]      = Data[WIDTH-1-b];
      assign stage_out_rev[b] = stage[SHW][WIDTH-1-b];
   end

   assign stage[0] = is_sll ? data_rev : Data;

   // Stage k moves the word right by 2**k; rotate refills from the bits dropped off the LSB.
   for (genvar k = 0; k < SHW; k++) begin : g_stage
      localparam int S = 1 << k;
      logic [S-1:0] hi;
      assign hi           = is_rot ? stage[k][S-1:0] : {S{fill}};
      assign stage[k+1]   = shamt[k] ? {hi, stage[k][WIDTH-1:S]} : stage[k];
   end

   assign shifted = is_sll ? stage_out_rev : stage[SHW];

endmodule

// File: rtl/shift_unit.sv
// rtl/shift_unit.sv - registered 32-bit shifter with valid qualifier
module shift_unit
   import shift_pkg::*;
#(
   parameter int WIDTH = SH_WIDTH,
   parameter int SHW   = SH_SHW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [1:0]       op,
   input  logic [SHW-1:0]   shamt,
   input  logic [WIDTH-1:0] Data,
   output logic [WIDTH-1:0] result,
   output logic             out_valid
);

   logic [WIDTH-1:0] core_out;
   logic [WIDTH-1:0] result_d;
   logic [WIDTH-1:0] result_q;
   logic             valid_d;
   logic             valid_q;

   shift_core #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_core (
      .op      (op),
      .shamt   (shamt),
      .Data    (Data),
      .shifted (core_out)
   );

   always_comb begin
      result_d = result_q;
      valid_d  = in_valid;
      if (in_valid) begin
         result_d = core_out;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         result_q <= result_d;
         valid_q  <= valid_d;
      end
   end

   assign result    = result_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_shift_unit.sv
// tb/tb_shift_unit.sv - randomized self-checking bench for shift_unit
module tb_shift_unit;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [1:0]  op;
   logic [4:0]  shamt;
   logic [31:0] Data;
   logic [31:0] result;
   logic        out_valid;

   int          n_tests;
   int          n_fail;
   logic [31:0] exp_q;

   shift_unit dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .op        (op),
      .shamt     (shamt),
      .Data      (Data),
      .result    (result),
      .out_valid (out_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_shift(input logic [1:0] o, input int s, input logic [31:0] d);
      logic [63:0] dd;
      dd = {d, d} >> s;
      case (o)
         2'd0:    return d << s;
         2'd1:    return d >> s;
         2'd2:    return $unsigned($signed(d) >>> s);
         default: return dd[31:0];
      endcase
   endfunction

   task automatic apply(input string tag, input logic [1:0] o, input logic [4:0] s,
                        input logic [31:0] d, input logic [31:0] exp);
      in_valid = 1'b1;
      op       = o;
      shamt    = s;
      Data     = d;
      exp_q    = exp;
      @(posedge clk);
      #1;
      check({tag, "_result"}, result, exp);
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      exp_q    = '0;
      rst      = 1'b1;
      in_valid = 1'b1;
      op       = 2'd0;
      shamt    = 5'd0;
      Data     = 32'hFFFF_FFFF;
      repeat (2) @(posedge clk);
      #1;
      check("reset_result", result, 32'd0);
      check("reset_valid", {31'd0, out_valid}, 32'd0);
      in_valid = 1'b0;
      rst      = 1'b0;
      @(posedge clk);
      #1;
      check("post_reset_result", result, 32'd0);
      check("post_reset_valid", {31'd0, out_valid}, 32'd0);

      apply("br_1", 2'd0, 5'd2, 32'd1, 32'd4);
      apply("br_3", 2'd0, 5'd2, 32'd3, 32'd12);
      apply("br_6", 2'd0, 5'd2, 32'd6, 32'd24);
      apply("br_wrap", 2'd0, 5'd2, 32'hC000_0001, 32'h0000_0004);

      apply("srl4", 2'd1, 5'd4, 32'h8000_00F0, 32'h0800_000F);
      apply("sra4", 2'd2, 5'd4, 32'h8000_00F0, 32'hF800_000F);
      apply("rotr1", 2'd3, 5'd1, 32'h0000_0001, 32'h8000_0000);
      apply("rotr8", 2'd3, 5'd8, 32'h1234_5678, 32'h7812_3456);
      for (int i = 0; i < 4; i++) begin
         apply("sh0", 2'(i), 5'd0, 32'h1234_5678, 32'h1234_5678);
      end
      apply("sll31", 2'd0, 5'd31, 32'h0000_0001, 32'h8000_0000);
      apply("sll31_b", 2'd0, 5'd31, 32'hFFFF_FFFE, 32'h0000_0000);
      apply("srl31", 2'd1, 5'd31, 32'h8000_0000, 32'h0000_0001);
      apply("sra31", 2'd2, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF);
      apply("sra31_pos", 2'd2, 5'd31, 32'h7FFF_FFFF, 32'h0000_0000);

      apply("hold_src", 2'd1, 5'd3, 32'hA5A5_0000, 32'h14B4_A000);
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         Data  = $urandom();
         op    = 2'($urandom_range(0, 3));
         shamt = 5'($urandom_range(0, 31));
         @(posedge clk);
         #1;
         check("hold_result", result, 32'h14B4_A000);
         check("hold_valid", {31'd0, out_valid}, 32'd0);
      end

      for (int i = 0; i < 1000; i++) begin
         logic v;
         v        = ($urandom_range(0, 9) != 0);
         in_valid = v;
         op       = 2'($urandom_range(0, 3));
         shamt    = 5'($urandom_range(0, 31));
         Data     = $urandom();
         if (v) exp_q = ref_shift(op, int'(shamt), Data);
         @(posedge clk);
         #1;
         check("rand_result", result, exp_q);
         check("rand_valid", {31'd0, out_valid}, {31'd0, v});
      end

      apply("pre_mid_rst", 2'd3, 5'd4, 32'h0000_00AB, 32'hB000_000A);
      in_valid = 1'b1;
      op       = 2'd0;
      shamt    = 5'd0;
      Data     = 32'hFFFF_FFFF;
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_result", result, 32'd0);
      check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      #1;
      check("rst_discard_result", result, 32'd0);
      check("rst_discard_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("after_rst_result", result, 32'd0);
      check("after_rst_valid", {31'd0, out_valid}, 32'd0);
      apply("after_rst_cap", 2'd1, 5'd1, 32'h0000_0010, 32'h0000_0008);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/shift_unit.md
Name: shift_unit

Overview:
- Registered 32-bit shifter for the CPU datapath.
- Serves branch-offset scaling (Data << 2) and the SLL/SRL/SRA/ROTR shift-class ALU operations.
- One-cycle latency, valid-qualified, no back-pressure.
- Datapath: a combinational barrel-shift core feeding an output register stage.

Parameters:
- WIDTH, 32, data width; must be a power of two.
- SHW, 5, shift-amount width; equals log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  Data/op/shamt are sampled on this clk edge when high
- op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROTR
- shamt  input  SHW  shift amount, 0..WIDTH-1
- Data  input  WIDTH  operand
- result  output  WIDTH  registered shift result
- out_valid  output  1  high for exactly one cycle when result is updated

Behaviour:
- Reset:
  - rst high clears result to 0 and out_valid to 0 immediately, independent of clk.
  - Both outputs hold 0 while rst is high.
  - First capture occurs on the first rising clk edge after rst deasserts.
- Capture:
  - On a rising clk edge with in_valid=1, result <= f(op, Data, shamt) and out_valid <= 1.
  - Latency is exactly 1 cycle.
  - A new op can be accepted every cycle.
- Idle:
  - On a rising edge with in_valid=0, out_valid <= 0 and result holds its previous value.
- Operations (unsigned shamt interpretation):
  - SLL: Data << shamt, zero fill from LSB.
  - SRL: Data >> shamt, zero fill from MSB.
  - SRA: Data >> shamt, fill with Data[WIDTH-1].
  - ROTR: bits shifted out of the LSB re-enter at the MSB.
- Boundary conditions:
  - shamt=0 passes Data unchanged for all ops.
  - shamt=WIDTH-1: SLL leaves only Data[0] in the MSB; SRL leaves only Data[WIDTH-1] in the LSB; SRA yields all-sign bits.
  - No shift amount of WIDTH or more is representable, so no overflow case exists.
- Reset asserted mid-operation:
  - A capture pending on the same edge is discarded.
  - out_valid stays 0 and result stays 0.
- Branch-offset usage: the CPU drives op=SLL, shamt=2; result = Data*4 modulo 2^WIDTH.
- Core implementation:
  - Log-stage barrel shifter: SHW mux stages of 1, 2, 4, 8, 16 bit positions.
  - No loops over shamt.
  - No behavioural variable shifts in the output register block.
- No X propagation: unknown op is impossible (2-bit, fully decoded).
- All outputs come directly from flops.

Decomposition:
- Package shift_pkg holds:
  - op encoding constants SH_SLL=2'b00, SH_SRL=2'b01, SH_SRA=2'b10, SH_ROTR=2'b11;
  - default WIDTH/SHW constants.
- Sub-module shift_core: purely combinational barrel shifter (op, shamt, Data -> shifted value).
- shift_unit adds the valid/result register stage and the reset.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with in_valid=1, Data=32'hFFFF_FFFF -> result=0 and out_valid=0 immediately; both stay 0 for the cycle after rst drops.
- Branch offset: op=SLL, shamt=2, Data=1, then 3, then 6 on consecutive cycles -> result 4, 12, 24 on the following cycles, out_valid high for each; Data=32'hC000_0001 -> 32'h0000_0004.
- Right shifts: Data=32'h8000_00F0, shamt=4 -> SRL gives 32'h0800_000F; SRA gives 32'hF800_000F.
- Rotate and extremes:
  - ROTR, Data=32'h0000_0001, shamt=1 -> 32'h8000_0000.
  - shamt=0, any op, Data=32'h1234_5678 -> unchanged.
  - SLL shamt=31, Data=1 -> 32'h8000_0000.
- Hold/valid: after one valid op, drive in_valid=0 for 3 cycles while changing Data -> result unchanged, out_valid=0.
- Random: 1000 random (op, shamt, Data) back-to-back -> compare against reference model, one-cycle latency.
